fwd_hazard_ctrl: RTL and testbench

- Scheduler for the decode-stage operand-forwarding muxes and the front-end pipeline registers.
- Keeps its own shadow of the destination registers in flight in E, M and W.
- Each cycle it produces the forward_t selects for rs1/rs2 (Result, PCplus4, Wd or None).
- Issues stall and flush controls for RAW hazards the decode muxes cannot resolve: producer in E, load in M, or a multi-cycle mul/div in E.

---
 rtl/fwd_hazard_ctrl.sv | 113 +++++++++++
 tb/tb_fwd_hazard_ctrl.sv | 139 +++++++++++++
 2 files changed

// File: rtl/fwd_hazard_ctrl.sv
// fwd_hazard_ctrl: decode-stage forwarding select and front-end hazard control.
// It keeps a shadow of the E/M/W destinations and drives the rs1/rs2 forward
// selects. It also drives stall/flush/hold controls for hazards the decode muxes
// cannot cover: a producer in E, a load in M, or a mul/div busy in E.
//
// Ports:
//   clk, reset        core clock, async active-low reset
//   d_valid           decode holds a valid instruction
//   d_rs1, d_rs2      decode sources
//   d_rd, d_wen       decode destination / writes-rd
//   d_kind            0=ALU 1=LOAD 2=LINK 3=MULDIV
//   redirect          branch/jump resolved in E, flush front end
//   fwd_a, fwd_b      forward selects: 0=None 1=Result 2=PCplus4 3=Wd
//   stall_f, stall_d  hold PC/fetch and F/D registers
//   flush_d, flush_e  clear F/D, bubble into D/E
//   e_hold            hold D/E while mul/div busy
module fwd_hazard_ctrl #(
  parameter int MULDIV_LAT = 4,
  parameter int CNT_W      = 3
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       d_valid,
  input  logic [4:0] d_rs1,
  input  logic [4:0] d_rs2,
  input  logic [4:0] d_rd,
  input  logic       d_wen,
  input  logic [1:0] d_kind,
  input  logic       redirect,
  output logic [1:0] fwd_a,
  output logic [1:0] fwd_b,
  output logic       stall_f,
  output logic       stall_d,
  output logic       flush_d,
  output logic       flush_e,
  output logic       e_hold
);
  localparam logic [1:0] K_ALU = 2'd0, K_LOAD = 2'd1, K_LINK = 2'd2, K_MULDIV = 2'd3;
  localparam logic [1:0] F_NONE = 2'd0, F_RESULT = 2'd1, F_PCP4 = 2'd2, F_WD = 2'd3;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(MULDIV_LAT - 1);

  // shadow slots
  logic             r_e_vld, r_m_vld, r_w_vld;
  logic [4:0]       r_e_rd,  r_m_rd,  r_w_rd;
  logic             r_e_wen, r_m_wen, r_w_wen;
  logic [1:0]       r_e_kind, r_m_kind;
  logic [CNT_W-1:0] r_cnt;

  logic w_busy, w_hazard, w_flush_e;
  logic w_e_hit, w_m_load_hit;

  // x0 is hard-wired zero: never forwarded, never a hazard
  function automatic logic match(input logic vld, input logic wen,
                                 input logic [4:0] rd, input logic [4:0] rs);
    return vld & wen & (rd == rs) & (rs != 5'd0);
  endfunction

  // M beats W; a load in M has no data yet, so it falls through (hazard stalls it)
  function automatic logic [1:0] sel(input logic m_hit, input logic [1:0] m_kind,
                                     input logic w_hit);
    if (m_hit && (m_kind == K_ALU || m_kind == K_MULDIV)) return F_RESULT;
    if (m_hit && m_kind == K_LINK)                        return F_PCP4;
    if (w_hit)                                            return F_WD;
    return F_NONE;
  endfunction

  always_comb begin
    w_busy       = r_e_vld & (r_e_kind == K_MULDIV) & (r_cnt != CNT_LAST);
    w_e_hit      = match(r_e_vld, r_e_wen, r_e_rd, d_rs1) |
                   match(r_e_vld, r_e_wen, r_e_rd, d_rs2);
    w_m_load_hit = (r_m_kind == K_LOAD) &
                   (match(r_m_vld, r_m_wen, r_m_rd, d_rs1) |
                    match(r_m_vld, r_m_wen, r_m_rd, d_rs2));
    w_hazard     = d_valid & (w_e_hit | w_m_load_hit | w_busy);
    // while busy D/E is held rather than bubbled
    w_flush_e    = (w_hazard & ~w_busy) | redirect;
  end

  always_comb begin
    fwd_a = sel(match(r_m_vld, r_m_wen, r_m_rd, d_rs1), r_m_kind,
                match(r_w_vld, r_w_wen, r_w_rd, d_rs1));
    fwd_b = sel(match(r_m_vld, r_m_wen, r_m_rd, d_rs2), r_m_kind,
                match(r_w_vld, r_w_wen, r_w_rd, d_rs2));
    // controls drop immediately when reset asserts, whatever the inputs
    stall_f = reset & w_hazard & ~redirect;
    stall_d = reset & w_hazard & ~redirect;
    flush_d = reset & redirect;
    flush_e = reset & w_flush_e;
    e_hold  = reset & w_busy;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_e_vld  <= 1'b0; r_e_rd <= '0; r_e_wen <= 1'b0; r_e_kind <= K_ALU;
      r_m_vld  <= 1'b0; r_m_rd <= '0; r_m_wen <= 1'b0; r_m_kind <= K_ALU;
      r_w_vld  <= 1'b0; r_w_rd <= '0; r_w_wen <= 1'b0;
      r_cnt    <= '0;
    end else begin
      r_w_vld <= r_m_vld; r_w_rd <= r_m_rd; r_w_wen <= r_m_wen;
      if (w_busy) begin
        r_cnt   <= r_cnt + 1'b1;
        r_m_vld <= 1'b0;
      end else begin
        r_cnt    <= '0;
        r_m_vld  <= r_e_vld; r_m_rd <= r_e_rd; r_m_wen <= r_e_wen; r_m_kind <= r_e_kind;
        r_e_vld  <= d_valid & ~w_flush_e;
        r_e_rd   <= d_rd;
        r_e_wen  <= d_wen;
        r_e_kind <= d_kind;
      end
    end
  end
endmodule

// File: tb/tb_fwd_hazard_ctrl.sv
// Directed bench for fwd_hazard_ctrl with hand-computed expected outputs.
module tb_fwd_hazard_ctrl;
  localparam logic [1:0] NONE = 2'd0, RES = 2'd1, PC4 = 2'd2, WD = 2'd3;
  localparam logic [1:0] ALU = 2'd0, LD = 2'd1, LNK = 2'd2, MD = 2'd3;

  logic       clk = 1'b0, reset = 1'b0;
  logic       d_valid = 1'b0, d_wen = 1'b0, redirect = 1'b0;
  logic [4:0] d_rs1 = '0, d_rs2 = '0, d_rd = '0;
  logic [1:0] d_kind = '0;
  logic [1:0] fwd_a, fwd_b;
  logic       stall_f, stall_d, flush_d, flush_e, e_hold;
  int n_chk = 0, n_err = 0;

  fwd_hazard_ctrl #(.MULDIV_LAT(4), .CNT_W(3)) dut (
    .clk(clk), .reset(reset), .d_valid(d_valid), .d_rs1(d_rs1), .d_rs2(d_rs2),
    .d_rd(d_rd), .d_wen(d_wen), .d_kind(d_kind), .redirect(redirect),
    .fwd_a(fwd_a), .fwd_b(fwd_b), .stall_f(stall_f), .stall_d(stall_d),
    .flush_d(flush_d), .flush_e(flush_e), .e_hold(e_hold));

  always #5 clk = ~clk;

  always @(negedge clk)
    if (reset) assert (!(e_hold && redirect)) else $error("redirect while mul/div busy");

  task automatic chk(input string tag, input logic [8:0] got, input logic [8:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %b expected %b (fa fb sf sd fd fe eh)", tag, got, exp);
    end
  endtask

  task automatic expo(input string tag, input logic [1:0] fa, input logic [1:0] fb,
                      input logic sf, input logic sd, input logic fd, input logic fe,
                      input logic eh);
    chk(tag, {fwd_a, fwd_b, stall_f, stall_d, flush_d, flush_e, e_hold},
             {fa, fb, sf, sd, fd, fe, eh});
  endtask

  // drive decode inputs and let combinational outputs settle before checking
  task automatic drv(input logic v, input logic [4:0] r1, input logic [4:0] r2,
                     input logic [4:0] rd, input logic w, input logic [1:0] k,
                     input logic rdr);
    d_valid = v; d_rs1 = r1; d_rs2 = r2; d_rd = rd; d_wen = w; d_kind = k; redirect = rdr;
    #2;
  endtask

  task automatic nxt();
    @(posedge clk); #1;
  endtask

  task automatic idle(input int n);
    repeat (n) begin drv(0, 0, 0, 0, 0, ALU, 0); nxt(); end
  endtask

  initial begin
    #1;
    // reset held with random inputs
    for (int i = 0; i < 3; i++) begin
      d_valid = 1'($urandom); d_rs1 = 5'($urandom); d_rs2 = 5'($urandom);
      d_rd = 5'($urandom); d_wen = 1'($urandom); d_kind = 2'($urandom);
      redirect = 1'($urandom);
      #2; expo("reset", NONE, NONE, 0, 0, 0, 0, 0);
      nxt();
    end
    reset = 1'b1;

    // ALU with no consumer
    drv(1, 0, 0, 5, 1, ALU, 0); expo("alu_solo_d", NONE, NONE, 0, 0, 0, 0, 0); nxt();
    drv(0, 0, 0, 0, 0, ALU, 0); expo("alu_solo_e", NONE, NONE, 0, 0, 0, 0, 0); nxt();
    idle(3);

    // ALU -> dependent rs1
    drv(1, 0, 0, 5, 1, ALU, 0); expo("alu_c0", NONE, NONE, 0, 0, 0, 0, 0); nxt();
    drv(1, 5, 0, 3, 1, ALU, 0); expo("alu_c1", NONE, NONE, 1, 1, 0, 1, 0); nxt();
    drv(1, 5, 0, 3, 1, ALU, 0); expo("alu_c2", RES, NONE, 0, 0, 0, 0, 0); nxt();
    idle(3);

    // rd = x0 never hazards or forwards
    drv(1, 0, 0, 0, 1, ALU, 0); nxt();
    drv(1, 0, 0, 3, 1, ALU, 0); expo("x0_c1", NONE, NONE, 0, 0, 0, 0, 0); nxt();
    drv(1, 0, 0, 3, 1, ALU, 0); expo("x0_c2", NONE, NONE, 0, 0, 0, 0, 0); nxt();
    idle(3);

    // LOAD -> dependent rs2: two stalls then Wd
    drv(1, 0, 0, 7, 1, LD, 0); nxt();
    drv(1, 0, 7, 3, 1, ALU, 0); expo("ld_c1", NONE, NONE, 1, 1, 0, 1, 0); nxt();
    drv(1, 0, 7, 3, 1, ALU, 0); expo("ld_c2", NONE, NONE, 1, 1, 0, 1, 0); nxt();
    drv(1, 0, 7, 3, 1, ALU, 0); expo("ld_c3", NONE, WD, 0, 0, 0, 0, 0); nxt();
    idle(3);

    // LINK, independent, consumer -> PCplus4 without stall
    drv(1, 0, 0, 1, 1, LNK, 0); nxt();
    drv(1, 3, 4, 2, 1, ALU, 0); expo("lnk_c1", NONE, NONE, 0, 0, 0, 0, 0); nxt();
    drv(1, 1, 0, 3, 1, ALU, 0); expo("lnk_c2", PC4, NONE, 0, 0, 0, 0, 0); nxt();
    idle(3);

    // rd=1 in both M (LINK) and W (ALU): M wins
    drv(1, 0, 0, 1, 1, ALU, 0); nxt();
    drv(1, 0, 0, 1, 1, LNK, 0); nxt();
    drv(0, 0, 0, 0, 0, ALU, 0); nxt();
    drv(1, 1, 1, 3, 1, ALU, 0); expo("mw_prio", PC4, PC4, 0, 0, 0, 0, 0); nxt();
    idle(3);

    // MULDIV rd=9, ALU rd=6 ahead of it shows M bubbling during hold
    drv(1, 0, 0, 6, 1, ALU, 0); nxt();
    drv(1, 0, 0, 9, 1, MD, 0); expo("md_c0", NONE, NONE, 0, 0, 0, 0, 0); nxt();
    drv(1, 9, 6, 3, 1, ALU, 0); expo("md_c1", NONE, RES, 1, 1, 0, 0, 1); nxt();
    drv(1, 9, 6, 3, 1, ALU, 0); expo("md_c2", NONE, WD, 1, 1, 0, 0, 1); nxt();
    drv(1, 9, 6, 3, 1, ALU, 0); expo("md_c3", NONE, NONE, 1, 1, 0, 0, 1); nxt();
    drv(1, 9, 6, 3, 1, ALU, 0); expo("md_c4", NONE, NONE, 1, 1, 0, 1, 0); nxt();
    drv(1, 9, 6, 3, 1, ALU, 0); expo("md_c5", RES, NONE, 0, 0, 0, 0, 0); nxt();
    idle(3);

    // redirect while consumer hazards on E
    drv(1, 0, 0, 5, 1, ALU, 0); nxt();
    drv(1, 5, 0, 3, 1, ALU, 1); expo("rdr_c1", NONE, NONE, 0, 0, 1, 1, 0); nxt();
    drv(1, 5, 0, 3, 1, ALU, 0); expo("rdr_c2", RES, NONE, 0, 0, 0, 0, 0); nxt();
    idle(3);

    // reset mid mul/div: immediate drop, counter restarts afterwards
    drv(1, 0, 0, 9, 1, MD, 0); nxt();
    drv(1, 9, 0, 3, 1, ALU, 0); expo("rst_md_busy", NONE, NONE, 1, 1, 0, 0, 1);
    reset = 1'b0; #1;
    expo("rst_async", NONE, NONE, 0, 0, 0, 0, 0);
    nxt(); reset = 1'b1;
    drv(1, 9, 0, 3, 1, ALU, 0); expo("rst_after", NONE, NONE, 0, 0, 0, 0, 0);
    drv(1, 0, 0, 9, 1, MD, 0); nxt();
    for (int i = 0; i < 3; i++) begin
      drv(1, 9, 0, 3, 1, ALU, 0); expo("md2_hold", NONE, NONE, 1, 1, 0, 0, 1); nxt();
    end
    drv(1, 9, 0, 3, 1, ALU, 0); expo("md2_last", NONE, NONE, 1, 1, 0, 1, 0); nxt();
    drv(1, 9, 0, 3, 1, ALU, 0); expo("md2_fwd", RES, NONE, 0, 0, 0, 0, 0); nxt();
    idle(2);

    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end
endmodule
